// File: rtl/dac_ramp_pkg.sv
// Shared widths, reset code and channel state encoding for the DAC setpoint ramp.
package dac_ramp_pkg;
    localparam int              DATA_W     = 16;
    localparam int              RATE_W     = 16;
    localparam logic [15:0]     RESET_CODE = 16'h8000;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ch_state_e;
endpackage

// File: rtl/dac_setpoint_ramp_if.sv
// Setpoint command bus: valid/ready handshake plus channel, target, step and rate.
interface dac_setpoint_ramp_if #(
    parameter int DATA_W = dac_ramp_pkg::DATA_W,
    parameter int RATE_W = dac_ramp_pkg::RATE_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_ch;
    logic [DATA_W-1:0] cmd_target;
    logic [DATA_W-1:0] cmd_step;
    logic [RATE_W-1:0] cmd_rate;

    modport master (
        output cmd_valid, cmd_ch, cmd_target, cmd_step, cmd_rate,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_target, cmd_step, cmd_rate,
        output cmd_ready
    );
endinterface

// File: rtl/dac_ramp_channel.sv
// One DAC channel: IDLE/RAMP FSM, inter-step counter and clamped step arithmetic.
module dac_ramp_channel #(
    parameter int                DATA_W     = dac_ramp_pkg::DATA_W,
    parameter int                RATE_W     = dac_ramp_pkg::RATE_W,
    parameter logic [DATA_W-1:0] RESET_CODE = dac_ramp_pkg::RESET_CODE
) (
    input  logic              clk_in,
    input  logic              rst_in_n,
    input  logic              load,
    input  logic [DATA_W-1:0] cmd_target,
    input  logic [DATA_W-1:0] cmd_step,
    input  logic [RATE_W-1:0] cmd_rate,
    output logic [DATA_W-1:0] code,
    output logic              busy,
    output logic              update
);
    import dac_ramp_pkg::*;

    ch_state_e         state_q, state_d;
    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [DATA_W-1:0] tgt_q, tgt_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic [DATA_W-1:0] code_q, code_d;
    logic              upd_q, upd_d;

    // One extra bit keeps the sign of target-current; magnitude then fits DATA_W+1 bits.
    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   mag;

    always_comb begin
        diff    = {1'b0, tgt_q} - {1'b0, code_q};
        mag     = diff[DATA_W] ? (~diff + (DATA_W+1)'(1)) : diff;

        state_d = state_q;
        cnt_d   = cnt_q;
        rate_d  = rate_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        code_d  = code_q;
        upd_d   = 1'b0;

        // A new command takes priority over a step due on the same edge.
        if (load) begin
            tgt_d   = cmd_target;
            step_d  = cmd_step;
            rate_d  = cmd_rate;
            cnt_d   = cmd_rate;
            state_d = RAMP;
        end else if (state_q == RAMP) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - RATE_W'(1);
            end else begin
                cnt_d = rate_q;
                if (step_q == '0 || mag <= {1'b0, step_q}) begin
                    code_d  = tgt_q;
                    state_d = IDLE;
                end else if (diff[DATA_W]) begin
                    code_d = code_q - step_q;
                end else begin
                    code_d = code_q + step_q;
                end
                upd_d = (code_d != code_q);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rate_q  <= '0;
            tgt_q   <= RESET_CODE;
            step_q  <= '0;
            code_q  <= RESET_CODE;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            code_q  <= code_d;
            upd_q   <= upd_d;
        end
    end

    assign code   = code_q;
    assign busy   = (state_q == RAMP);
    assign update = upd_q;
endmodule

// File: rtl/dac_setpoint_ramp.sv
// Two-channel DAC setpoint ramp: command decode, ready and the shared update strobe.
module dac_setpoint_ramp #(
    parameter int                DATA_W     = dac_ramp_pkg::DATA_W,
    parameter int                RATE_W     = dac_ramp_pkg::RATE_W,
    parameter logic [DATA_W-1:0] RESET_CODE = dac_ramp_pkg::RESET_CODE
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    dac_setpoint_ramp_if.slave  cmd,
    output logic [DATA_W-1:0]   DAC1_out,
    output logic [DATA_W-1:0]   DAC2_out,
    output logic                dac_update,
    output logic [1:0]          busy
);
    import dac_ramp_pkg::*;

    logic                   ready_q, ready_d;
    logic                   accept;
    logic [1:0]             load;
    logic [1:0]             upd;
    logic [1:0][DATA_W-1:0] code;

    // Ready comes up one cycle after reset release and then stays high.
    assign ready_d = 1'b1;

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) ready_q <= 1'b0;
        else           ready_q <= ready_d;
    end

    always_comb begin
        accept  = cmd.cmd_valid & ready_q;
        load[0] = accept & ~cmd.cmd_ch;
        load[1] = accept &  cmd.cmd_ch;
    end

    for (genvar g = 0; g < 2; g++) begin : g_ch
        dac_ramp_channel #(
            .DATA_W     (DATA_W),
            .RATE_W     (RATE_W),
            .RESET_CODE (RESET_CODE)
        ) u_ch (
            .clk_in     (clk_in),
            .rst_in_n   (rst_in_n),
            .load       (load[g]),
            .cmd_target (cmd.cmd_target),
            .cmd_step   (cmd.cmd_step),
            .cmd_rate   (cmd.cmd_rate),
            .code       (code[g]),
            .busy       (busy[g]),
            .update     (upd[g])
        );
    end

    assign cmd.cmd_ready = ready_q;
    assign DAC1_out      = code[0];
    assign DAC2_out      = code[1];
    assign dac_update    = |upd;
endmodule

// File: tb/tb_dac_setpoint_ramp.sv
// Directed scenarios plus randomized commands against a time-based channel model.
module tb_dac_setpoint_ramp;
    localparam int DW = 16;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] dac1, dac2;
    logic          dac_update;
    logic [1:0]    busy;
    int            n_pass = 0;
    int            n_total = 0;

    dac_setpoint_ramp_if #(.DATA_W(DW), .RATE_W(RW)) cmd_if();

    dac_setpoint_ramp #(.DATA_W(DW), .RATE_W(RW), .RESET_CODE(16'h8000)) dut (
        .clk_in     (clk),
        .rst_in_n   (rst_n),
        .cmd        (cmd_if),
        .DAC1_out   (dac1),
        .DAC2_out   (dac2),
        .dac_update (dac_update),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: each channel schedules its next step at an absolute edge index.
    longint      cyc = 0;
    logic [15:0] m_out [2];
    logic [15:0] m_tgt [2];
    logic [15:0] m_step[2];
    int          m_rate[2];
    longint      m_next[2];
    bit          m_busy[2];
    bit          m_upd;
    bit          m_ready;

    always @(posedge clk) begin : model
        int          d, a;
        logic [15:0] o;
        bit          u;
        cyc <= cyc + 1;
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_out[c]  <= 16'h8000;
                m_busy[c] <= 1'b0;
            end
            m_upd   <= 1'b0;
            m_ready <= 1'b0;
        end else begin
            u = 1'b0;
            for (int c = 0; c < 2; c++) begin
                if (m_ready && cmd_if.cmd_valid && (int'(cmd_if.cmd_ch) == c)) begin
                    m_tgt[c]  <= cmd_if.cmd_target;
                    m_step[c] <= cmd_if.cmd_step;
                    m_rate[c] <= int'(cmd_if.cmd_rate);
                    m_next[c] <= cyc + longint'(cmd_if.cmd_rate) + 1;
                    m_busy[c] <= 1'b1;
                end else if (m_busy[c] && cyc == m_next[c]) begin
                    d = int'(m_tgt[c]) - int'(m_out[c]);
                    a = (d < 0) ? -d : d;
                    if (m_step[c] == 0 || a <= int'(m_step[c])) begin
                        o = m_tgt[c];
                        m_busy[c] <= 1'b0;
                    end else if (d > 0) begin
                        o = m_out[c] + m_step[c];
                    end else begin
                        o = m_out[c] - m_step[c];
                    end
                    if (o != m_out[c]) u = 1'b1;
                    m_out[c]  <= o;
                    m_next[c] <= m_next[c] + longint'(m_rate[c]) + 1;
                end
            end
            m_upd   <= u;
            m_ready <= 1'b1;
        end
    end

    // Drive one command from a negedge; returns at the negedge after its accept edge.
    task automatic send(input bit ch, input logic [15:0] tgt, input logic [15:0] step, input int rate);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_ch     = ch;
        cmd_if.cmd_target = tgt;
        cmd_if.cmd_step   = step;
        cmd_if.cmd_rate   = 16'(rate);
        @(negedge clk);
        cmd_if.cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_ch = 1'b0;
        cmd_if.cmd_target = '0; cmd_if.cmd_step = '0; cmd_if.cmd_rate = '0;
        repeat (3) @(negedge clk);
        n_total++; if (dac1 !== 16'h8000) $display("FAIL reset_dac1 got %h want 8000", dac1); else n_pass++;
        n_total++; if (dac2 !== 16'h8000) $display("FAIL reset_dac2 got %h want 8000", dac2); else n_pass++;
        n_total++; if (busy !== 2'b00) $display("FAIL reset_busy got %b want 00", busy); else n_pass++;
        n_total++; if (dac_update !== 1'b0) $display("FAIL reset_update got %b want 0", dac_update); else n_pass++;
        n_total++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", cmd_if.cmd_ready); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL release_ready_first got %b want 0", cmd_if.cmd_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL release_ready got %b want 1", cmd_if.cmd_ready); else n_pass++;
        n_total++; if (dac1 !== 16'h8000) $display("FAIL release_dac1 got %h want 8000", dac1); else n_pass++;
    endtask

    task automatic test_ramp_up();
        logic [15:0] e;
        send(1'b0, 16'h8010, 16'd4, 0);
        n_total++; if (busy[0] !== 1'b1) $display("FAIL ramp_up_busy_start got %b want 1", busy[0]); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            e = 16'h8000 + 16'(4 * i);
            n_total++; if (dac1 !== e) $display("FAIL ramp_up_dac1 step %0d got %h want %h", i, dac1, e); else n_pass++;
            n_total++; if (busy[0] !== (i < 4)) $display("FAIL ramp_up_busy step %0d got %b want %b", i, busy[0], (i < 4)); else n_pass++;
            n_total++; if (dac_update !== 1'b1) $display("FAIL ramp_up_update step %0d got %b want 1", i, dac_update); else n_pass++;
            n_total++; if (dac2 !== 16'h8000) $display("FAIL ramp_up_dac2 step %0d got %h want 8000", i, dac2); else n_pass++;
        end
    endtask

    task automatic test_clamp_down();
        logic [15:0] e;
        int pulses = 0;
        send(1'b1, 16'h0000, 16'h3000, 2);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            e = (i < 3) ? 16'h8000 : (i < 6) ? 16'h5000 : (i < 9) ? 16'h2000 : 16'h0000;
            if (dac_update === 1'b1) pulses++;
            n_total++; if (dac2 !== e) $display("FAIL clamp_dac2 edge k+%0d got %h want %h", i, dac2, e); else n_pass++;
            n_total++; if (dac_update !== (i % 3 == 0)) $display("FAIL clamp_update edge k+%0d got %b want %b", i, dac_update, (i % 3 == 0)); else n_pass++;
        end
        n_total++; if (pulses != 3) $display("FAIL clamp_pulses got %0d want 3", pulses); else n_pass++;
        n_total++; if (busy !== 2'b00) $display("FAIL clamp_busy_end got %b want 00", busy); else n_pass++;
        n_total++; if (dac1 !== 16'h8010) $display("FAIL clamp_dac1_untouched got %h want 8010", dac1); else n_pass++;
    endtask

    task automatic test_jump();
        int cnt;
        send(1'b0, 16'hFFFF, 16'h0000, 3);
        cnt = (busy[0] === 1'b1) ? 1 : 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (busy[0] === 1'b1) cnt++;
            n_total++; if (dac1 !== ((i < 4) ? 16'h8010 : 16'hFFFF)) $display("FAIL jump_dac1 edge k+%0d got %h", i, dac1); else n_pass++;
        end
        n_total++; if (cnt != 4) $display("FAIL jump_busy_cycles got %0d want 4", cnt); else n_pass++;
    endtask

    task automatic test_same_target();
        int pulses = 0;
        send(1'b0, 16'hFFFF, 16'd5, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (dac_update === 1'b1) pulses++;
            n_total++; if (dac1 !== 16'hFFFF) $display("FAIL same_dac1 edge k+%0d got %h want ffff", i, dac1); else n_pass++;
            n_total++; if (busy[0] !== (i < 2)) $display("FAIL same_busy edge k+%0d got %b want %b", i, busy[0], (i < 2)); else n_pass++;
        end
        n_total++; if (pulses != 0) $display("FAIL same_pulses got %0d want 0", pulses); else n_pass++;
    endtask

    task automatic test_retarget();
        logic [15:0] e;
        send(1'b0, 16'h6C00, 16'h0000, 0);
        @(negedge clk);
        n_total++; if (dac1 !== 16'h6C00) $display("FAIL retarget_start got %h want 6c00", dac1); else n_pass++;
        send(1'b0, 16'h9000, 16'h0400, 1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            e = (i < 2) ? 16'h6C00 : (i < 4) ? 16'h7000 : 16'h7400;
            n_total++; if (dac1 !== e) $display("FAIL retarget_up edge k+%0d got %h want %h", i, dac1, e); else n_pass++;
        end
        // Accepted on edge k+6, which is also a step edge for the running ramp.
        send(1'b0, 16'h7000, 16'h0200, 1);
        n_total++; if (dac1 !== 16'h7400) $display("FAIL retarget_hold got %h want 7400", dac1); else n_pass++;
        n_total++; if (dac_update !== 1'b0) $display("FAIL retarget_no_update got %b want 0", dac_update); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            e = (i < 2) ? 16'h7400 : (i < 4) ? 16'h7200 : 16'h7000;
            n_total++; if (dac1 !== e) $display("FAIL retarget_down step %0d got %h want %h", i, dac1, e); else n_pass++;
            n_total++; if (busy[0] !== (i < 4)) $display("FAIL retarget_busy step %0d got %b want %b", i, busy[0], (i < 4)); else n_pass++;
            n_total++; if (dac_update !== (i == 2 || i == 4)) $display("FAIL retarget_update step %0d got %b", i, dac_update); else n_pass++;
        end
    endtask

    task automatic test_reset_midramp();
        send(1'b0, 16'h0000, 16'd1, 0);
        send(1'b1, 16'hFFFF, 16'd1, 0);
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 2'b11) $display("FAIL midramp_busy_before got %b want 11", busy); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_total++; if (dac1 !== 16'h8000) $display("FAIL midramp_dac1 got %h want 8000", dac1); else n_pass++;
        n_total++; if (dac2 !== 16'h8000) $display("FAIL midramp_dac2 got %h want 8000", dac2); else n_pass++;
        n_total++; if (busy !== 2'b00) $display("FAIL midramp_busy got %b want 00", busy); else n_pass++;
        n_total++; if (dac_update !== 1'b0) $display("FAIL midramp_update got %b want 0", dac_update); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (dac1 !== 16'h8000 || busy !== 2'b00) $display("FAIL midramp_after got %h/%b want 8000/00", dac1, busy); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_total++; if (dac1 !== m_out[0]) $display("FAIL rand_dac1 cyc %0d got %h want %h", i, dac1, m_out[0]); else n_pass++;
            n_total++; if (dac2 !== m_out[1]) $display("FAIL rand_dac2 cyc %0d got %h want %h", i, dac2, m_out[1]); else n_pass++;
            n_total++; if (busy !== {m_busy[1], m_busy[0]}) $display("FAIL rand_busy cyc %0d got %b want %b%b", i, busy, m_busy[1], m_busy[0]); else n_pass++;
            n_total++; if (dac_update !== m_upd) $display("FAIL rand_update cyc %0d got %b want %b", i, dac_update, m_upd); else n_pass++;
            n_total++; if (cmd_if.cmd_ready !== m_ready) $display("FAIL rand_ready cyc %0d got %b want %b", i, cmd_if.cmd_ready, m_ready); else n_pass++;
            cmd_if.cmd_valid  = ($urandom_range(0, 5) == 0);
            cmd_if.cmd_ch     = 1'($urandom_range(0, 1));
            cmd_if.cmd_target = 16'($urandom);
            cmd_if.cmd_step   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h2000));
            cmd_if.cmd_rate   = 16'($urandom_range(0, 4));
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_clamp_down();
        test_jump();
        test_same_target();
        test_retarget();
        test_reset_midramp();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
